transmit: RTL and testbench
===========================

TRANSMIT -- requirements
Module: transmit

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, Enable ticks per serial bit.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: DATA  input  8  databus byte to transmit.
REQ-005 Port: Enable  input  1  baud tick, one clk cycle wide, OVERSAMPLE per bit time.
REQ-006 Port: IORW  input  1  1 = read, 0 = write.
REQ-007 Port: IOADDR  input  2  register select; 2'b00 = transmit buffer.
REQ-008 Port: TxD  output  1  serial line, registered, idles high.
REQ-009 Port: TBR  output  1  transmit buffer ready; 1 = a write will be accepted.

Function
REQ-010 Write strobe SHALL be {IORW,IOADDR} == 3'b000; a strobe with TBR=0 SHALL be ignored, with no state change.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 An accepted strobe in IDLE SHALL latch DATA into an 8-bit shifter, clear the tick and bit counters, enter START, and drive TBR=0 and TxD=0 from the next edge.
REQ-013 The tick counter SHALL advance only on clk edges with Enable=1, and wrap from OVERSAMPLE-1 to 0; bit end = Enable=1 with counter == OVERSAMPLE-1.
REQ-014 Each bit SHALL last exactly OVERSAMPLE Enable pulses; with Enable=0 all state and TxD SHALL hold.
REQ-015 Frame SHALL be: START (TxD=0), DATA (8 bits, LSB first, shifter shifts right at each bit end), STOP (TxD=1), i.e. 10 bit times.
REQ-016 The 3-bit bit counter SHALL advance at each DATA bit end; DATA→STOP after bit 7 ends.
REQ-017 At STOP bit end, the FSM SHALL go to IDLE and TBR SHALL return to 1 on the same edge.
REQ-018 A strobe in the same cycle as STOP bit end SHALL be ignored (TBR still 0 at that cycle).
REQ-019 DATA changes after acceptance SHALL not affect the frame in flight.
REQ-020 In IDLE, TxD SHALL be 1.

Reset
REQ-021 When rst=1 at a clk edge: state=IDLE, TxD=1, TBR=1, tick and bit counters=0, shifter=8'h00, hold register empty; this applies mid-frame, aborting it.
REQ-022 rst SHALL take priority over a simultaneous write strobe and Enable.

Configuration
REQ-023 Macro TX_HOLD_EN SHALL compile in an 8-bit holding register with a full flag.
REQ-024 With TX_HOLD_EN: TBR = hold empty; a strobe in IDLE loads the shifter directly (REQ-012); a strobe while START/DATA/STOP loads hold and clears TBR next edge.
REQ-025 With TX_HOLD_EN: at STOP bit end with hold full, the FSM SHALL go straight to START with hold contents (no idle cycles), mark hold empty, and set TBR=1 on that edge.
REQ-026 With TX_HOLD_EN: a strobe coinciding with STOP bit end and hold empty SHALL load the shifter directly and enter START.
REQ-027 Without TX_HOLD_EN, behaviour SHALL be exactly REQ-010..REQ-020; there SHALL be no hold logic.

Verification
REQ-028 Reset, write 8'hA5, Enable every 4th clk -> TxD 0,1,0,1,0,0,1,0,1,1, each bit 16 Enable pulses wide; TBR=0 for 160 Enable pulses, then 1.
REQ-029 Write 8'h3C while TBR=0 (no hold) -> ignored; the frame carries the first byte; no second frame.
REQ-030 Hold Enable=0 for 50 clk mid-DATA -> TxD and TBR frozen; the frame resumes with correct bit widths.
REQ-031 Assert rst in bit 4 of 8'hFF -> next edge TxD=1, TBR=1; a following write 8'h00 yields a clean frame.
REQ-032 TX_HOLD_EN: write 8'h11 then 8'h22 during the first frame -> TBR=0 after the second write; two back-to-back frames with no idle-high cycles between the STOP and START bits; TBR=1 at the first STOP end.
REQ-033 Loopback TxD into the existing receiver with the same Enable -> received byte equals the written byte for 8'h00, 8'h55, 8'hFF.

Source files
------------

// File: rtl/transmit.sv
// Serial transmitter: 8N1 frame, LSB first, one bit per OVERSAMPLE Enable ticks.
// Define TX_HOLD_EN to add a one-byte holding register for back-to-back frames.
module transmit #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] DATA,
    input  logic       Enable,
    input  logic       IORW,
    input  logic [1:0] IOADDR,
    output logic       TxD,
    output logic       TBR
);

    // state    | meaning
    // ST_IDLE  | line high, waiting for a write strobe
    // ST_START | start bit (TxD=0)
    // ST_DATA  | eight data bits, LSB first
    // ST_STOP  | stop bit (TxD=1)
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shifter;
    logic          strobe;
    logic          bit_end;

`ifdef TX_HOLD_EN
    logic [7:0]    hold;
    logic          hold_full;
`endif

    assign strobe  = ({IORW, IOADDR} == 3'b000) && TBR;
    assign bit_end = Enable && (tick_cnt == TW'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= 8'h00;
            TxD      <= 1'b1;
            TBR      <= 1'b1;
`ifdef TX_HOLD_EN
            hold      <= 8'h00;
            hold_full <= 1'b0;
`endif
        end else begin
`ifdef TX_HOLD_EN
            // Mid-frame writes park in the hold register; a write landing on the
            // stop-bit end goes straight to the shifter instead (handled below).
            if (strobe && state != ST_IDLE && !(state == ST_STOP && bit_end)) begin
                hold      <= DATA;
                hold_full <= 1'b1;
                TBR       <= 1'b0;
            end
`endif
            case (state)
                ST_IDLE: begin
                    TxD <= 1'b1;
                    if (strobe) begin
                        shifter  <= DATA;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_START;
                        TxD      <= 1'b0;
`ifndef TX_HOLD_EN
                        TBR      <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (Enable) begin
                        if (bit_end) begin
                            tick_cnt <= '0;
                            state    <= ST_DATA;
                            TxD      <= shifter[0];
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (Enable) begin
                        if (bit_end) begin
                            tick_cnt <= '0;
                            shifter  <= {1'b0, shifter[7:1]};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_STOP;
                                TxD   <= 1'b1;
                            end else begin
                                TxD <= shifter[1];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (Enable) begin
                        if (bit_end) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
`ifdef TX_HOLD_EN
                            if (hold_full) begin
                                shifter   <= hold;
                                hold_full <= 1'b0;
                                TBR       <= 1'b1;
                                state     <= ST_START;
                                TxD       <= 1'b0;
                            end else if (strobe) begin
                                shifter <= DATA;
                                state   <= ST_START;
                                TxD     <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                                TxD   <= 1'b1;
                            end
`else
                            state <= ST_IDLE;
                            TxD   <= 1'b1;
                            TBR   <= 1'b1;
`endif
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    TxD   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmit.sv
// Bench for transmit: frame-position model checked every cycle, plus a bench-side
// receiver on TxD that decodes frames for literal byte/bit checks.
module tb_transmit;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] DATA;
    logic       Enable;
    logic       IORW;
    logic [1:0] IOADDR;
    logic       TxD;
    logic       TBR;

    int checks = 0;
    int errors = 0;

    transmit #(.OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .DATA(DATA), .Enable(Enable),
        .IORW(IORW), .IOADDR(IOADDR), .TxD(TxD), .TBR(TBR)
    );

    always #5 clk = ~clk;

    // Enable: one clk wide, every 4th clk while en_run is set.
    logic       en_run = 1'b0;
    logic [1:0] ediv = 2'd0;
    always @(negedge clk) begin
        ediv   = ediv + 2'd1;
        Enable = en_run && (ediv == 2'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a frame is 10*OS Enable pulses; the line level follows the pulse position.
    logic       m_valid = 1'b0;
    logic       m_busy;
    int         m_pos;
    logic [7:0] m_cur;
    logic       m_hfull;
    logic [7:0] m_hold;
    logic       m_s;
    logic       m_fe;

    function automatic logic m_tbr();
`ifdef TX_HOLD_EN
        return !m_hfull;
`else
        return !m_busy;
`endif
    endfunction

    function automatic logic m_txd();
        int idx;
        if (!m_busy) return 1'b1;
        idx = m_pos / OS;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_cur[idx-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_pos   = 0;
            m_hfull = 1'b0;
            m_cur   = 8'h00;
            m_hold  = 8'h00;
        end else if (m_valid) begin
            m_s  = (IORW == 1'b0) && (IOADDR == 2'b00) && m_tbr();
            m_fe = 1'b0;
            if (m_busy && Enable) begin
                m_pos++;
                if (m_pos == 10*OS) m_fe = 1'b1;
            end
            if (m_fe) begin
`ifdef TX_HOLD_EN
                if (m_hfull) begin
                    m_cur = m_hold; m_hfull = 1'b0; m_pos = 0;
                end else if (m_s) begin
                    m_cur = DATA; m_pos = 0;
                end else begin
                    m_busy = 1'b0;
                end
`else
                m_busy = 1'b0;
`endif
            end else if (m_s) begin
                if (!m_busy) begin
                    m_busy = 1'b1; m_pos = 0; m_cur = DATA;
                end else begin
                    m_hold = DATA; m_hfull = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("txd", TxD, m_txd());
            chk("tbr", TBR, m_tbr());
        end
    end

    // Bench receiver: samples mid-bit (pulse 8 of each bit) on the same Enable.
    logic       rx_busy = 1'b0;
    int         rx_k;
    logic [9:0] rx_sh;
    logic [9:0] rx_fb;
    logic [7:0] rx_q[$];
    int         rx_count = 0;

    always @(posedge clk) begin
        if (rst) begin
            rx_busy = 1'b0;
        end else if (Enable) begin
            if (!rx_busy) begin
                if (TxD == 1'b0) begin
                    rx_busy = 1'b1;
                    rx_k    = 1;
                end
            end else begin
                rx_k++;
            end
            if (rx_busy) begin
                if ((rx_k - 1) % OS == OS/2 - 1) rx_sh[(rx_k - 1) / OS] = TxD;
                if (rx_k == 10*OS) begin
                    rx_busy = 1'b0;
                    rx_fb   = rx_sh;
                    rx_q.push_back(rx_sh[8:1]);
                    rx_count++;
                end
            end
        end
    end

    int tbr_en_cnt = 0;
    always @(posedge clk) if (Enable && !TBR) tbr_en_cnt++;

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        DATA   = d;
        IORW   = 1'b0;
        IOADDR = 2'b00;
        @(negedge clk);
        IORW   = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (rx_count < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("frame_done", 32'(rx_count >= n), 32'd1);
    endtask

    initial begin
        logic [7:0] lb [3];
        int base;
        lb[0] = 8'h00; lb[1] = 8'h55; lb[2] = 8'hFF;
        rst = 1'b1; DATA = 8'h00; IORW = 1'b1; IOADDR = 2'b00; Enable = 1'b0;
        en_run = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd", TxD, 1'b1);
        chk("rst_tbr", TBR, 1'b1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic frame 8'hA5
        tbr_en_cnt = 0;
        wr(8'hA5);
        chk("a5_start_txd", TxD, 1'b0);
`ifndef TX_HOLD_EN
        chk("a5_start_tbr", TBR, 1'b0);
`endif
        wait_frames(1, 2000);
        chk("a5_byte", rx_q[0], 8'hA5);
        chk("a5_bits", rx_fb, 10'b1101001010);
        repeat (4) @(negedge clk);
        chk("a5_tbr_after", TBR, 1'b1);
`ifndef TX_HOLD_EN
        chk("a5_tbr_low_pulses", tbr_en_cnt, 160);
`endif

        // Non-strobe accesses are ignored
        @(negedge clk); IORW = 1'b0; IOADDR = 2'b01;
        @(negedge clk); IORW = 1'b1; IOADDR = 2'b00;
        @(negedge clk);
        chk("decode_ignored", TBR, 1'b1);

`ifndef TX_HOLD_EN
        // Write while busy is dropped
        wr(8'h5A);
        repeat (100) @(negedge clk);
        wr(8'h3C);
        wait_frames(2, 2000);
        repeat (1500) @(negedge clk);
        chk("busy_frames", rx_count, 2);
        chk("busy_byte", rx_q[1], 8'h5A);
`endif

        // Enable held off mid-DATA
        base = rx_count;
        wr(8'hC3);
        repeat (200) @(negedge clk);
        en_run = 1'b0;
        repeat (50) @(negedge clk);
        en_run = 1'b1;
        wait_frames(base + 1, 2000);
        chk("freeze_byte", rx_q[base], 8'hC3);

        // Reset inside bit 4 of 8'hFF
        base = rx_count;
        wr(8'hFF);
        repeat (340) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_txd", TxD, 1'b1);
        chk("abort_tbr", TBR, 1'b1);
        wr(8'h00);
        wait_frames(base + 1, 2000);
        chk("abort_byte", rx_q[base], 8'h00);
        repeat (700) @(negedge clk);
        chk("abort_frames", rx_count, base + 1);

        // Loopback bytes
        for (int i = 0; i < 3; i++) begin
            base = rx_count;
            wr(lb[i]);
            wait_frames(base + 1, 2000);
            chk("loop_byte", rx_q[base], lb[i]);
            repeat (10) @(negedge clk);
        end

`ifdef TX_HOLD_EN
        // Back-to-back frames through the hold register
        begin
            int c = 0;
            base = rx_count;
            wr(8'h11);
            repeat (40) @(negedge clk);
            wr(8'h22);
            chk("hold_tbr_low", TBR, 1'b0);
            while (!TBR && c < 2000) begin
                @(negedge clk);
                c++;
            end
            chk("hold_tbr_rise", TBR, 1'b1);
            chk("hold_no_idle", TxD, 1'b0);
            wait_frames(base + 2, 2000);
            chk("hold_byte0", rx_q[base], 8'h11);
            chk("hold_byte1", rx_q[base+1], 8'h22);
        end
`endif

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
